// File: rtl/dnn_fixed_pkg.sv
// Shared fixed-point definitions for the DNN datapath: default word format,
// saturation limits and the accumulator FSM state type.
package dnn_fixed_pkg;

  localparam int WIDTH     = 16;
  localparam int INT_BITS  = 5;
  localparam int FRAC_BITS = WIDTH - 1 - INT_BITS;

  localparam logic [WIDTH-1:0] FX_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] FX_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

  // A single-term accumulator still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Combinational range check and narrowing of the wide accumulator sum.
// Build option ACC_SATURATE_EN: clamp out-of-range sums instead of wrapping.
module fixed_saturate #(
  parameter int WIDTH      = 16,
  parameter int GUARD_BITS = 4
) (
  input  logic signed [WIDTH+GUARD_BITS-1:0] sum_i,
  output logic        [WIDTH-1:0]            data_o,
  output logic                               overflow_o
);

  localparam int AW = WIDTH + GUARD_BITS;

  // The sum fits in WIDTH bits exactly when every bit from the narrow sign
  // position upward agrees with the wide sign bit.
  logic [GUARD_BITS:0] topBits;

  assign topBits    = sum_i[AW-1:WIDTH-1];
  assign overflow_o = !((&topBits) || !(|topBits));

`ifdef ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    data_o = sum_i[WIDTH-1:0];
    if (overflow_o) begin
      data_o = sum_i[AW-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign data_o = sum_i[WIDTH-1:0];
`endif

endmodule

// File: rtl/fixed_accumulator.sv
// Sums FAN_IN consecutive signed products into one result on a valid/ready stream.
// Wrap vs. clamp of out-of-range results is selected by ACC_SATURATE_EN in fixed_saturate.
module fixed_accumulator #(
  parameter int WIDTH      = dnn_fixed_pkg::WIDTH,
  parameter int INT_BITS   = dnn_fixed_pkg::INT_BITS,
  parameter int FAN_IN     = 4,
  parameter int GUARD_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] out_data,
  output logic                    out_overflow
);

  import dnn_fixed_pkg::*;

  localparam int              AW       = WIDTH + GUARD_BITS;
  localparam int              CW       = cnt_width(FAN_IN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(FAN_IN - 1);

  acc_state_t             state_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   inExt;
  logic        [CW-1:0]   cnt_q;
  logic                   outValid_q;
  logic        [WIDTH-1:0] outData_q;
  logic                   outOverflow_q;
  logic        [WIDTH-1:0] satData;
  logic                   satOverflow;
  logic                   lastTerm;

  // Products are sign-extended into the guard bits so FAN_IN terms can never
  // wrap the internal sum; only the final narrowing can overflow.
  assign inExt    = {{GUARD_BITS{in_data[WIDTH-1]}}, in_data};
  assign acc_d    = acc_q + inExt;
  assign lastTerm = (cnt_q == LAST_CNT);

  fixed_saturate #(
    .WIDTH      (WIDTH),
    .GUARD_BITS (GUARD_BITS)
  ) u_saturate (
    .sum_i      (acc_d),
    .data_o     (satData),
    .overflow_o (satOverflow)
  );

  // ACC gathers terms; the last one is narrowed straight into the output
  // registers and HOLD presents them until downstream takes the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ACC;
      acc_q         <= '0;
      cnt_q         <= '0;
      outValid_q    <= 1'b0;
      outData_q     <= '0;
      outOverflow_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (lastTerm) begin
              outData_q     <= satData;
              outOverflow_q <= satOverflow;
              outValid_q    <= 1'b1;
              acc_q         <= '0;
              cnt_q         <= '0;
              state_q       <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        default: begin
          state_q <= ACC;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == ACC);
  assign out_valid    = outValid_q;
  assign out_data     = outData_q;
  assign out_overflow = outOverflow_q;

endmodule

// File: tb/tb_fixed_accumulator.sv
// Scoreboard bench for fixed_accumulator: directed groups push expected sums,
// a negedge monitor checks latency on each valid rise and data on each handshake.
module tb_fixed_accumulator;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_overflow;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        ovf;
    int          expCycle;
  } exp_t;

  exp_t sbQ[$];
  int   riseCycles[$];
  int   cycle      = 0;
  int   vecCount   = 0;
  int   missCount  = 0;

  fixed_accumulator #(
    .WIDTH      (16),
    .INT_BITS   (5),
    .FAN_IN     (4),
    .GUARD_BITS (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  // Free-running clock and a cycle index used for latency bookkeeping.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic flagFailure(input string name, input string detail);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Present one term and hold it until an edge where in_ready was high.
  task automatic applyStimulus(input logic [15:0] data, output int acceptCycle);
    int waitCycles;
    bit taken;
    waitCycles = 0;
    taken      = 1'b0;
    in_valid   = 1'b1;
    in_data    = data;
    while (!taken && waitCycles < 20) begin
      @(negedge clk);
      taken = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      waitCycles++;
    end
    in_valid = 1'b0;
    if (!taken) flagFailure("accept_timeout", "in_ready never asserted");
    acceptCycle = cycle;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Four terms form one result; the expected word is queued once the last is taken.
  task automatic sendGroup(input string name, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2, input logic [15:0] t3, input bit bubbles,
                           input logic [15:0] expData, input bit expOvf);
    logic [15:0] terms[4];
    int acceptCycle;
    exp_t e;
    terms[0] = t0;
    terms[1] = t1;
    terms[2] = t2;
    terms[3] = t3;
    acceptCycle = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(terms[i], acceptCycle);
      if (bubbles && i < 3) idleCycle();
    end
    e.name     = name;
    e.data     = expData;
    e.ovf      = expOvf;
    e.expCycle = acceptCycle;
    sbQ.push_back(e);
  endtask

  // Monitor: valid must rise in the cycle after the last term is taken, and
  // each handshake retires the oldest expected result.
  initial begin
    bit   prevValid;
    exp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prevValid = 1'b0;
        continue;
      end
      if (out_valid === 1'b1 && !prevValid) begin
        riseCycles.push_back(cycle);
        if (sbQ.size() == 0) flagFailure("unexpected_result", $sformatf("out_data 0x%0h with nothing pending", out_data));
        else checkOutput({sbQ[0].name, "_latency"}, cycle, sbQ[0].expCycle);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput({e.name, "_data"}, {16'h0, out_data}, {16'h0, e.data});
        checkOutput({e.name, "_overflow"}, {31'h0, out_overflow}, {31'h0, e.ovf});
      end
      prevValid = (out_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dummy;
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;
    dummy     = 0;

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_out_data", {16'h0, out_data}, 32'h0);
    checkOutput("reset_out_overflow", {31'h0, out_overflow}, 32'h0);
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
    reset_n = 1'b1;
    idleCycle();

    $display("[TB] basic sum");
    sendGroup("basic", 16'h0AA0, 16'hF560, 16'h0600, 16'h0080, 1'b0, 16'h0680, 1'b0);
    repeat (2) idleCycle();

    $display("[TB] positive overflow");
`ifdef ACC_SATURATE_EN
    sendGroup("pos_ovf", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
`else
    sendGroup("pos_ovf", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFC, 1'b1);
`endif
    repeat (2) idleCycle();

    $display("[TB] negative overflow");
`ifdef ACC_SATURATE_EN
    sendGroup("neg_ovf", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1);
`else
    sendGroup("neg_ovf", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
`endif
    repeat (2) idleCycle();

    $display("[TB] bubbles and backpressure");
    out_ready = 1'b0;
    sendGroup("bubble", 16'h0AA0, 16'hF560, 16'h0600, 16'h0080, 1'b1, 16'h0680, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_out_valid", i), {31'h0, out_valid}, 32'h1);
      checkOutput($sformatf("stall%0d_out_data", i), {16'h0, out_data}, 32'h0680);
      checkOutput($sformatf("stall%0d_in_ready", i), {31'h0, in_ready}, 32'h0);
      idleCycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    idleCycle();
    @(negedge clk);
    checkOutput("release_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("release_in_ready", {31'h0, in_ready}, 32'h1);
    idleCycle();

    $display("[TB] reset mid-operation");
    applyStimulus(16'h0400, dummy);
    applyStimulus(16'h0400, dummy);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midreset_in_ready", {31'h0, in_ready}, 32'h1);
    reset_n = 1'b1;
    idleCycle();
    sendGroup("reset_recover", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0, 16'h1000, 1'b0);
    repeat (2) idleCycle();

    $display("[TB] back-to-back results");
    sendGroup("b2b_first", 16'h0200, 16'h0200, 16'h0200, 16'h0200, 1'b0, 16'h0800, 1'b0);
    sendGroup("b2b_second", 16'h0200, 16'h0200, 16'h0200, 16'h0200, 1'b0, 16'h0800, 1'b0);
    repeat (3) idleCycle();
    n = riseCycles.size();
    if (n < 2) flagFailure("b2b_spacing", "fewer than two results observed");
    else checkOutput("b2b_spacing", riseCycles[n-1] - riseCycles[n-2], 32'd5);

    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
